// File: rtl/lru_arbiter.sv
// lru_arbiter: N-way least-recently-granted arbiter with a registered,
// resettable rank table, grant-lock for multi-cycle transfers, one-hot
// grant and encoded grant index. All outputs come straight from flops.
module lru_arbiter #(
   parameter int N  = 4,
   parameter int IW = $clog2(N)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [N-1:0]    req,
   input  logic            lock,
   output logic [N-1:0]    grant,
   output logic            grant_valid,
   output logic [IW-1:0]   grant_id,
   output logic [N*IW-1:0] rank
);

   // Rank N-1 is the highest priority; rank 0 is the most recently granted.
   logic [IW-1:0] rank_q [N];
   logic [IW-1:0] rank_d [N];

   logic [N-1:0]  grant_q;
   logic          grant_valid_q;
   logic [IW-1:0] grant_id_q;

   logic          hold;
   logic          any_req;
   logic [IW-1:0] win;
   logic [IW-1:0] win_rank;

   // Lock keeps the current holder only while it is still requesting.
   assign hold = lock && grant_valid_q && req[grant_id_q];

   // Pick the requester holding the largest rank; ranks are unique so no tie.
   always_comb begin
      // NOTE: every variable gets a default before the loop so no latch is inferred.
      any_req  = 1'b0;
      win      = '0;
      win_rank = '0;
      for (int i = 0; i < N; i++) begin
         if (req[i] && (!any_req || rank_q[i] > win_rank)) begin
            any_req  = 1'b1;
            win      = IW'(i);
            win_rank = rank_q[i];
         end
      end
   end

   // Next rank table on a grant event: the winner drops to 0 and every entry
   // that sat below it moves up by one, so the table stays a permutation.
   always_comb begin
      for (int j = 0; j < N; j++) begin
         rank_d[j] = rank_q[j];
         if (IW'(j) == win)
            rank_d[j] = '0;
         else if (rank_q[j] < win_rank)
            rank_d[j] = rank_q[j] + IW'(1);
      end
   end

   // Grant and rank state: hold under lock, go idle with no request, else grant.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: the rank table is small and must start as a valid permutation,
         // so unlike a data memory it is explicitly reset.
         for (int i = 0; i < N; i++)
            rank_q[i] <= IW'(i);
         grant_q       <= '0;
         grant_valid_q <= 1'b0;
         grant_id_q    <= '0;
      end else if (hold) begin
         // NOTE: state is updated with non-blocking assignments so every flop
         // samples the pre-edge values; holding simply leaves them untouched.
         grant_q <= grant_q;
      end else if (!any_req) begin
         grant_q       <= '0;
         grant_valid_q <= 1'b0;
         grant_id_q    <= '0;
      end else begin
         grant_q       <= N'(1) << win;
         grant_valid_q <= 1'b1;
         grant_id_q    <= win;
         for (int i = 0; i < N; i++)
            rank_q[i] <= rank_d[i];
      end
   end

   // Flatten the rank table into the debug port.
   always_comb begin
      rank = '0;
      for (int i = 0; i < N; i++)
         rank[i*IW +: IW] = rank_q[i];
   end

   assign grant       = grant_q;
   assign grant_valid = grant_valid_q;
   assign grant_id    = grant_id_q;

endmodule

// File: tb/tb_lru_arbiter.sv
// Directed testbench for lru_arbiter at N=4, N=8 and N=2.
module tb_lru_arbiter;

   logic clk = 1'b0;
   logic rst_n;

   logic [3:0]  req4;
   logic        lock4;
   logic [3:0]  grant4;
   logic        valid4;
   logic [1:0]  id4;
   logic [7:0]  rank4;

   logic [7:0]  req8;
   logic        lock8;
   logic [7:0]  grant8;
   logic        valid8;
   logic [2:0]  id8;
   logic [23:0] rank8;

   logic [1:0]  req2;
   logic        lock2;
   logic [1:0]  grant2;
   logic        valid2;
   logic [0:0]  id2;
   logic [1:0]  rank2;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   lru_arbiter #(.N(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .req(req4), .lock(lock4),
      .grant(grant4), .grant_valid(valid4), .grant_id(id4), .rank(rank4)
   );

   lru_arbiter #(.N(8)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .req(req8), .lock(lock8),
      .grant(grant8), .grant_valid(valid8), .grant_id(id8), .rank(rank8)
   );

   lru_arbiter #(.N(2)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .req(req2), .lock(lock2),
      .grant(grant2), .grant_valid(valid2), .grant_id(id2), .rank(rank2)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // 1 when the packed table holds each value 0..n-1 exactly once.
   function automatic logic is_perm(input logic [31:0] r, input int n, input int iw);
      int seen = 0;
      for (int i = 0; i < n; i++) begin
         int v = int'((r >> (i*iw)) & ((32'd1 << iw) - 32'd1));
         if (v >= n) return 1'b0;
         seen = seen | (1 << v);
      end
      return seen == ((1 << n) - 1);
   endfunction

   // Rank tables must be permutations in every cycle.
   always @(negedge clk) begin
      check("perm4", 32'(is_perm(32'(rank4), 4, 2)), 32'd1);
      check("perm8", 32'(is_perm(32'(rank8), 8, 3)), 32'd1);
      check("perm2", 32'(is_perm(32'(rank2), 2, 1)), 32'd1);
   end

   // Advance one clock and settle just after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk4(input string tag, input logic [3:0] g, input logic [1:0] id);
      check({tag, "_grant"}, 32'(grant4), 32'(g));
      check({tag, "_valid"}, 32'(valid4), 32'(g != 4'b0));
      check({tag, "_id"},    32'(id4),    32'(id));
   endtask

   // Pulse reset between edges (called just after an edge).
   task automatic do_reset();
      rst_n = 1'b0;
      #3;
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0;
      req4 = '0; lock4 = 1'b0;
      req8 = '0; lock8 = 1'b0;
      req2 = '0; lock2 = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // Reset state
      chk4("reset", 4'b0000, 2'd0);
      check("reset_rank", 32'(rank4), 32'hE4);

      // Round robin, N=4
      rst_n = 1'b1;
      req4  = 4'b1111;
      step(); chk4("rr0", 4'b1000, 2'd3);
      check("rr0_rank", 32'(rank4), 32'h39);
      step(); chk4("rr1", 4'b0100, 2'd2);
      step(); chk4("rr2", 4'b0010, 2'd1);
      step(); chk4("rr3", 4'b0001, 2'd0);
      step(); chk4("rr4", 4'b1000, 2'd3);

      // Single continuous requester, then a competitor
      do_reset();
      req4 = 4'b0010;
      step(); chk4("solo0", 4'b0010, 2'd1);
      step(); chk4("solo1", 4'b0010, 2'd1);
      step(); chk4("solo2", 4'b0010, 2'd1);
      check("solo_rank", 32'(rank4), 32'hE1);
      req4 = 4'b0011;
      step(); chk4("solo_comp", 4'b0001, 2'd0);

      // Idle
      do_reset();
      req4 = 4'b0000;
      step(); chk4("idle0", 4'b0000, 2'd0);
      step(); chk4("idle1", 4'b0000, 2'd0);
      check("idle_rank", 32'(rank4), 32'hE4);

      // Lock while idle has no effect, then hold, then release
      lock4 = 1'b1;
      step(); chk4("lock_idle", 4'b0000, 2'd0);
      req4 = 4'b0010;
      step(); chk4("lock_first", 4'b0010, 2'd1);
      req4 = 4'b0011;
      step(); chk4("lock_hold", 4'b0010, 2'd1);
      check("lock_hold_rank", 32'(rank4), 32'hE1);
      lock4 = 1'b0;
      step(); chk4("lock_release", 4'b0001, 2'd0);

      // Lock with all requesting; holder drops its request
      do_reset();
      lock4 = 1'b1;
      req4  = 4'b1111;
      step(); chk4("lk0", 4'b1000, 2'd3);
      step(); chk4("lk1", 4'b1000, 2'd3);
      step(); chk4("lk2", 4'b1000, 2'd3);
      step(); chk4("lk3", 4'b1000, 2'd3);
      check("lk_rank", 32'(rank4), 32'h39);
      req4 = 4'b0111;
      step(); chk4("lk_drop", 4'b0100, 2'd2);
      check("lk_drop_rank", 32'(rank4), 32'h4E);
      step(); chk4("lk_hold2", 4'b0100, 2'd2);

      // Asynchronous reset mid-lock, no clock edge
      #3;
      rst_n = 1'b0;
      #1;
      chk4("async_rst", 4'b0000, 2'd0);
      check("async_rst_rank", 32'(rank4), 32'hE4);
      rst_n = 1'b1;
      lock4 = 1'b0;
      req4  = 4'b1111;
      step(); chk4("post_rst", 4'b1000, 2'd3);

      // Round robin, N=8
      req4 = 4'b0000;
      do_reset();
      req8 = 8'hFF;
      for (int k = 0; k < 9; k++) begin
         int exp_id;
         step();
         exp_id = 7 - (k % 8);
         check("rr8_grant", 32'(grant8), 32'd1 << exp_id);
         check("rr8_id",    32'(id8),    32'(exp_id));
         check("rr8_valid", 32'(valid8), 32'd1);
      end
      req8 = 8'h00;

      // Round robin, N=2
      do_reset();
      req2 = 2'b11;
      for (int k = 0; k < 3; k++) begin
         int exp_id;
         step();
         exp_id = 1 - (k % 2);
         check("rr2_grant", 32'(grant2), 32'd1 << exp_id);
         check("rr2_id",    32'(id2),    32'(exp_id));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
